// File: rtl/touch_key_decoder.sv
// Touch-panel key decoder: coordinates -> key codes with debounce and events.
// Optional auto-repeat of key_press while held: define TOUCH_KEY_AUTOREPEAT_EN.
module touch_key_decoder #(
   parameter int ROWS          = 3,
   parameter int COLS          = 4,
   parameter int GRID_X0       = 10,
   parameter int GRID_Y0       = 10,
   parameter int KEY_W         = 140,
   parameter int KEY_H         = 130,
   parameter int PITCH_X       = 150,
   parameter int PITCH_Y       = 170,
   parameter int SIDE_N        = 6,
   parameter int SIDE_X0       = 612,
   parameter int SIDE_Y0       = 157,
   parameter int SIDE_W        = 118,
   parameter int SIDE_H        = 54,
   parameter int SIDE_PITCH    = 80,
   parameter int CODE_W        = 5,
   parameter int DEBOUNCE_CYC  = 4,
   parameter int RELEASE_CYC   = 4,
   parameter int REPEAT_DELAY  = 1000,
   parameter int REPEAT_PERIOD = 200
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       touch_data,
   input  logic              touch_valid,
   output logic [CODE_W-1:0] key_code,
   output logic              key_press,
   output logic              key_release,
   output logic              key_held
);

   localparam bit CfgOk = ((1 << CODE_W) > (ROWS * COLS + SIDE_N))
                          && (DEBOUNCE_CYC >= 1) && (RELEASE_CYC >= 1)
                          && (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);

   if (!CfgOk) begin : g_cfg_check
      $error("touch_key_decoder: inconsistent parameters");
   end

   localparam int CNT_MAX = (DEBOUNCE_CYC > RELEASE_CYC) ?
                            DEBOUNCE_CYC : RELEASE_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      PRESSED,
      REL
   } state_t;

   state_t            state_q, state_d;
   logic [CODE_W-1:0] raw_q, raw_d;
   logic [CODE_W-1:0] cand_q, cand_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic              press_q, press_d;
   logic              rel_q, rel_d;
   logic              held_q, held_d;
   logic [16:0]       x17, y17;

`ifdef TOUCH_KEY_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                            REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   logic [RPT_W-1:0] rpt_q, rpt_d, rpt_inc, rpt_lim;
   logic             rpt_per_q, rpt_per_d;

   assign rpt_inc = rpt_q + 1'b1;
   assign rpt_lim = rpt_per_q ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY);
`endif

   // Zero-extend to 17 bits so the parameter sums below never wrap.
   assign x17     = {1'b0, touch_data[31:16]};
   assign y17     = {1'b0, touch_data[15:0]};
   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      raw_d = '0;
      if (touch_valid) begin
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               if ((raw_d == '0)
                   && (x17 > 17'(GRID_X0 + c * PITCH_X))
                   && (x17 < 17'(GRID_X0 + c * PITCH_X + KEY_W))
                   && (y17 > 17'(GRID_Y0 + r * PITCH_Y))
                   && (y17 < 17'(GRID_Y0 + r * PITCH_Y + KEY_H))) begin
                  raw_d = CODE_W'(r * COLS + c + 1);
               end
            end
         end
         for (int k = 0; k < SIDE_N; k++) begin
            if ((raw_d == '0)
                && (x17 > 17'(SIDE_X0))
                && (x17 < 17'(SIDE_X0 + SIDE_W))
                && (y17 > 17'(SIDE_Y0 + k * SIDE_PITCH))
                && (y17 < 17'(SIDE_Y0 + k * SIDE_PITCH + SIDE_H))) begin
               raw_d = CODE_W'(ROWS * COLS + k + 1);
            end
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      code_d    = code_q;
      press_d   = 1'b0;
      rel_d     = 1'b0;
      held_d    = held_q;
`ifdef TOUCH_KEY_AUTOREPEAT_EN
      rpt_d     = rpt_q;
      rpt_per_d = rpt_per_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (raw_q != '0) begin
               cand_d = raw_q;
               if (DEBOUNCE_CYC == 1) begin
                  state_d = PRESSED;
                  cnt_d   = '0;
                  code_d  = raw_q;
                  press_d = 1'b1;
                  held_d  = 1'b1;
`ifdef TOUCH_KEY_AUTOREPEAT_EN
                  rpt_d     = '0;
                  rpt_per_d = 1'b0;
`endif
               end else begin
                  state_d = ARM;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         ARM: begin
            if (raw_q == cand_q) begin
               if (cnt_inc == CNT_W'(DEBOUNCE_CYC)) begin
                  state_d = PRESSED;
                  cnt_d   = '0;
                  code_d  = cand_q;
                  press_d = 1'b1;
                  held_d  = 1'b1;
`ifdef TOUCH_KEY_AUTOREPEAT_EN
                  rpt_d     = '0;
                  rpt_per_d = 1'b0;
`endif
               end else begin
                  cnt_d = cnt_inc;
               end
            end else if (raw_q == '0) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cand_d = raw_q;
               cnt_d  = CNT_W'(1);
            end
         end
         PRESSED: begin
            if (raw_q == cand_q) begin
`ifdef TOUCH_KEY_AUTOREPEAT_EN
               if (rpt_inc == rpt_lim) begin
                  press_d   = 1'b1;
                  rpt_d     = '0;
                  rpt_per_d = 1'b1;
               end else begin
                  rpt_d = rpt_inc;
               end
`endif
            end else begin
`ifdef TOUCH_KEY_AUTOREPEAT_EN
               rpt_d     = '0;
               rpt_per_d = 1'b0;
`endif
               if (RELEASE_CYC == 1) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  rel_d   = 1'b1;
                  held_d  = 1'b0;
               end else begin
                  state_d = REL;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         REL: begin
            if (raw_q == cand_q) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_inc == CNT_W'(RELEASE_CYC)) begin
               state_d = IDLE;
               cnt_d   = '0;
               rel_d   = 1'b1;
               held_d  = 1'b0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         raw_q     <= '0;
         cand_q    <= '0;
         code_q    <= '0;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         rel_q     <= 1'b0;
         held_q    <= 1'b0;
`ifdef TOUCH_KEY_AUTOREPEAT_EN
         rpt_q     <= '0;
         rpt_per_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         raw_q     <= raw_d;
         cand_q    <= cand_d;
         code_q    <= code_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         rel_q     <= rel_d;
         held_q    <= held_d;
`ifdef TOUCH_KEY_AUTOREPEAT_EN
         rpt_q     <= rpt_d;
         rpt_per_q <= rpt_per_d;
`endif
      end
   end

   assign key_code    = code_q;
   assign key_press   = press_q;
   assign key_release = rel_q;
   assign key_held    = held_q;

endmodule
